// File: rtl/add_pkg.sv
// Shared constants, op encoding and helpers for the pipelined
// carry-select adder.
package add_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_BLOCK  = 8;
    localparam int DEF_STAGES = 2;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    // 4-bit carry-lookahead group: returns {cout, sum[3:0]}.
    function automatic logic [4:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;
        g     = a & b;
        p     = a ^ b;
        cc[0] = c;
        cc[1] = g[0] | (p[0] & c);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c);
        cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return {cc[4], p ^ cc[3:0]};
    endfunction

endpackage

// File: rtl/csel_block.sv
// Combinational BLOCK-bit carry-select adder: two lookahead chains
// (carry-in 0 and 1) built from 4-bit groups, picked by cin.
// Ports: a, b (BLOCK) operands; cin carry-in; sum (BLOCK); cout.
module csel_block
    import add_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    localparam int NG = BLOCK / 4;

    logic [BLOCK-1:0] w_s0;
    logic [BLOCK-1:0] w_s1;
    logic [NG:0]      w_c0;
    logic [NG:0]      w_c1;

    assign w_c0[0] = 1'b0;
    assign w_c1[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NG; g++) begin : g_grp
            assign {w_c0[g+1], w_s0[g*4 +: 4]} =
                cla4(a[g*4 +: 4], b[g*4 +: 4], w_c0[g]);
            assign {w_c1[g+1], w_s1[g*4 +: 4]} =
                cla4(a[g*4 +: 4], b[g*4 +: 4], w_c1[g]);
        end
    endgenerate

    assign sum  = cin ? w_s1 : w_s0;
    assign cout = cin ? w_c1[NG] : w_c0[NG];

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, cin, sub in;
// out_valid/out_ready, sum, cout, ovf out.
module pipe_csel_adder
    import add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = nblk(WIDTH, BLOCK);
    localparam int SPS  = NBLK / STAGES;
    localparam int SW   = SPS * BLOCK;

    generate
        if (WIDTH < BLOCK || WIDTH % BLOCK != 0) begin : g_chk_w
            $error("WIDTH must be a non-zero multiple of BLOCK");
        end
        if (BLOCK < 4 || BLOCK % 4 != 0) begin : g_chk_b
            $error("BLOCK must be a non-zero multiple of 4");
        end
        if (STAGES < 1 || STAGES > NBLK || NBLK % STAGES != 0) begin : g_chk_s
            $error("STAGES must divide WIDTH/BLOCK");
        end
    endgenerate

    op_e w_op;
    logic w_adv;

    // Per-stage inputs (w_*i) and registered outputs (w_*q).
    logic [WIDTH-1:0] w_ai [STAGES];
    logic [WIDTH-1:0] w_bi [STAGES];
    logic [WIDTH-1:0] w_si [STAGES];
    logic             w_ci [STAGES];
    logic             w_vi [STAGES];
    logic [WIDTH-1:0] w_aq [STAGES];
    logic [WIDTH-1:0] w_bq [STAGES];
    logic [WIDTH-1:0] w_sq [STAGES];
    logic             w_cq [STAGES];
    logic             w_vq [STAGES];

    logic [WIDTH-1:0] w_res;
    logic [NBLK-1:0]  w_bcin;
    logic [NBLK-1:0]  w_bco;
    logic             w_ovf;
    logic             r_ovf;

    assign w_op = op_e'(sub);

    // Subtraction is a + ~b + 1; cin only matters for addition.
    assign w_ai[0] = a;
    assign w_bi[0] = (w_op == OP_SUB) ? ~b : b;
    assign w_ci[0] = (w_op == OP_SUB) | cin;
    assign w_si[0] = '0;
    assign w_vi[0] = in_valid;

    assign out_valid = w_vq[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign w_adv     = in_ready;

    genvar k;
    genvar j;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stg
            logic             r_v;
            logic             r_c;
            logic [WIDTH-1:0] r_s;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] w_nxt;

            if (k > 0) begin : g_link
                assign w_ai[k] = w_aq[k-1];
                assign w_bi[k] = w_bq[k-1];
                assign w_si[k] = w_sq[k-1];
                assign w_ci[k] = w_cq[k-1];
                assign w_vi[k] = w_vq[k-1];
            end

            // Splice this stage's resolved slice into the partial sum.
            always_comb begin
                w_nxt = w_si[k];
                w_nxt[k*SW +: SW] = w_res[k*SW +: SW];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_s <= '0;
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_v <= w_vi[k];
                    if (w_vi[k]) begin
                        r_s <= w_nxt;
                        r_a <= w_ai[k];
                        r_b <= w_bi[k];
                        r_c <= w_bco[(k+1)*SPS-1];
                    end
                end
            end

            assign w_vq[k] = r_v;
            assign w_cq[k] = r_c;
            assign w_sq[k] = r_s;
            assign w_aq[k] = r_a;
            assign w_bq[k] = r_b;
        end

        for (j = 0; j < NBLK; j++) begin : g_blk
            localparam int K = j / SPS;

            // First block of a stage takes the registered stage carry.
            if (j % SPS == 0) begin : g_cfirst
                assign w_bcin[j] = w_ci[K];
            end else begin : g_cchain
                assign w_bcin[j] = w_bco[j-1];
            end

            csel_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a   (w_ai[K][j*BLOCK +: BLOCK]),
                .b   (w_bi[K][j*BLOCK +: BLOCK]),
                .cin (w_bcin[j]),
                .sum (w_res[j*BLOCK +: BLOCK]),
                .cout(w_bco[j])
            );
        end
    endgenerate

    // Carry into the MSB recovered from its sum bit, xored with carry out.
    assign w_ovf = w_ai[STAGES-1][WIDTH-1] ^ w_bi[STAGES-1][WIDTH-1]
                 ^ w_res[WIDTH-1] ^ w_bco[NBLK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv && w_vi[STAGES-1]) begin
            r_ovf <= w_ovf;
        end
    end

    assign sum  = w_sq[STAGES-1];
    assign cout = w_cq[STAGES-1];
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Self-checking bench for pipe_csel_adder: directed vectors, stall and
// reset sequences on the default build, random stream on a 32/4/8 build.
module tb_pipe_csel_adder;
    import add_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1, cout, ovf;
    logic [63:0] a = '0, b = '0, sum;

    logic        in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, sub2 = 1'b0;
    logic        out_valid2, out_ready2 = 1'b1, cout2, ovf2;
    logic [31:0] a2 = '0, b2 = '0, sum2;

    pipe_csel_adder #(.WIDTH(64), .BLOCK(8), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    pipe_csel_adder #(.WIDTH(32), .BLOCK(4), .STAGES(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp2_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        c;
        logic        o;
    } vec_t;

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb);
        exp_t e;
        logic [64:0] r;
        logic [63:0] yy;
        yy  = sb ? ~y : y;
        r   = {1'b0, x} + {1'b0, yy} + {64'd0, (sb | ci)};
        e.s = r[63:0];
        e.c = r[64];
        e.o = (x[63] == yy[63]) && (r[63] != x[63]);
        return e;
    endfunction

    function automatic exp2_t model2(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb, input int t);
        exp2_t e;
        logic [32:0] r;
        logic [31:0] yy;
        yy    = sb ? ~y : y;
        r     = {1'b0, x} + {1'b0, yy} + {32'd0, (sb | ci)};
        e.s   = r[31:0];
        e.c   = r[32];
        e.o   = (x[31] == yy[31]) && (r[31] != x[31]);
        e.acc = t;
        return e;
    endfunction

    exp_t        sbq[$];
    exp2_t       q2[$];
    logic [63:0] out_log[$];
    int          out_cnt = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          held_v = 1'b0;
    logic [65:0] held;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) check("stall_hold", {sum, cout, ovf}, held);
            held_v = out_valid && !out_ready;
            held   = {sum, cout, ovf};
            if (out_valid && out_ready) begin
                out_cnt++;
                out_log.push_back(sum);
                check("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_result", {sum, cout, ovf}, {e.s, e.c, e.o});
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(a, b, cin, sub));
        end
    end

    always @(negedge clk) begin
        exp2_t e;
        if (rst) begin
            q2.delete();
        end else begin
            if (out_valid2 && out_ready2) begin
                check("sb2_nonempty", q2.size() != 0, 1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    check("sb2_result", {sum2, cout2, ovf2}, {e.s, e.c, e.o});
                    if (lat_chk) check("sb2_latency", cyc + 1 - e.acc, 8);
                end
            end
            if (in_valid2 && in_ready2)
                q2.push_back(model2(a2, b2, cin2, sub2, cyc + 1));
        end
    end

    task automatic run2(input int nbeats, input bit rnd_ready);
        int sent = 0;
        int cycles = 0;
        bit acc;
        in_valid2 = 1'b0;
        while (sent < nbeats && cycles < 60000) begin
            if (!in_valid2) begin
                in_valid2 = ($urandom_range(0, 3) != 0);
                a2   = $urandom;
                b2   = $urandom;
                cin2 = 1'($urandom_range(0, 1));
                sub2 = 1'($urandom_range(0, 1));
            end
            out_ready2 = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            acc = in_valid2 && in_ready2;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                sent++;
                in_valid2 = 1'b0;
            end
        end
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        check("run2_budget", sent, nbeats);
    endtask

    task automatic drain2();
        int n = 0;
        while (q2.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("q2_drained", q2.size(), 0);
    endtask

    vec_t tbl[11];

    initial begin
        int lat;
        int i;
        int t;
        int n;
        int cnt0;
        bit acc;

        tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'd0, 1'b1, 1'b0};
        tbl[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[2]  = '{64'd5, 64'd7, 1'b0, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        tbl[4]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
        tbl[5]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[6]  = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        tbl[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tbl[8]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
        tbl[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        tbl[10] = '{64'h00FF_00FF_00FF_00FF, 64'hFF01_FF01_FF01_FF01,
                    1'b0, 1'b0, 64'h0001_0001_0001_0000, 1'b1, 1'b0};

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout_ovf", {cout, ovf}, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1);

        for (int v = 0; v < 11; v++) begin
            @(posedge clk);
            #1;
            a = tbl[v].a;
            b = tbl[v].b;
            cin = tbl[v].cin;
            sub = tbl[v].sub;
            in_valid = 1'b1;
            check("tbl_in_ready", in_ready, 1);
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
                if (lat == 1) in_valid = 1'b0;
            end while (!out_valid && lat < 20);
            check("tbl_latency", lat, 2);
            check("tbl_sum", sum, tbl[v].s);
            check("tbl_cout", cout, tbl[v].c);
            check("tbl_ovf", ovf, tbl[v].o);
        end

        @(posedge clk);
        #1;
        out_log.delete();
        i = 1;
        t = 0;
        while (i <= 10 && t < 100) begin
            t++;
            out_ready = !(t >= 4 && t <= 6);
            a = 64'(i);
            b = 64'(i);
            cin = 1'b0;
            sub = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (t >= 4 && t <= 6) check("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_log.size() < 10 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stream_count", out_log.size(), 10);
        for (int k = 0; k < out_log.size(); k++)
            check("stream_order", out_log[k], 64'(2 * (k + 1)));

        @(posedge clk);
        #1;
        a = 64'd3;
        b = 64'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 64'd10;
        b = 64'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_pre_out_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_sum", sum, 0);
        check("rst_async_flags", {cout, ovf}, 0);
        check("rst_async_in_ready", in_ready, 1);
        cnt0 = out_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_release_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_ghost", out_cnt - cnt0, 0);

        lat_chk = 1'b1;
        run2(200, 1'b0);
        drain2();
        lat_chk = 1'b0;
        run2(10000, 1'b1);
        drain2();
        check("q1_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
